// File: rtl/seq_detector_moore_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_moore_param
// Description : Parametrised Moore serial pattern detector with registered
//               one-cycle match flag, saturating match counter and fill level.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_moore_param #(
    parameter int                  PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1101,
    parameter int                  CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           w,
    input  logic                           w_valid,
    input  logic                           overlap_en,
    input  logic                           clear,
    output logic                           z,
    output logic [CNT_W-1:0]               match_count,
    output logic [$clog2(PAT_LEN+1)-1:0]   fill
);

    localparam int                 FILL_W      = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]  c_FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [CNT_W-1:0]   r_count;
    logic               r_z;

    logic [PAT_LEN-1:0] w_hist_n;
    logic [FILL_W-1:0]  w_fill_n;
    logic               w_hit;

    always_comb begin
        w_hist_n = {r_hist[PAT_LEN-2:0], w};
        w_fill_n = (r_fill == c_FILL_FULL) ? r_fill : r_fill + 1'b1;
        w_hit    = (w_fill_n == c_FILL_FULL) && (w_hist_n == PATTERN);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_z     <= 1'b0;
        end else if (w_valid) begin
            r_hist <= w_hist_n;
            if (w_hit) begin
                r_z <= 1'b1;
                if (r_count != c_CNT_MAX) begin
                    r_count <= r_count + 1'b1;
                end
                // Non-overlapping mode keeps the history bits but demands a
                // full pattern's worth of fresh bits before the next hit.
                r_fill <= overlap_en ? c_FILL_FULL : '0;
            end else begin
                r_z    <= 1'b0;
                r_fill <= w_fill_n;
            end
        end else begin
            r_z <= 1'b0;
        end
    end

    assign z           = r_z;
    assign match_count = r_count;
    assign fill        = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_moore_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_moore_param
// Description : Self-checking bench for seq_detector_moore_param (1101, 4 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_moore_param;

    localparam logic [3:0] c_PAT = 4'b1101;

    typedef struct {
        logic       z;
        logic [7:0] cnt;
        logic [1:0] cnt_sat;
        logic [2:0] fill;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       w = 1'b0;
    logic       w_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       clear = 1'b0;
    logic       z;
    logic [7:0] match_count;
    logic [2:0] fill;
    logic       z_sat;
    logic [1:0] match_count_sat;
    logic [2:0] fill_sat;

    int n_total = 0;
    int n_pass  = 0;

    logic [3:0] m_hist = '0;
    logic [2:0] m_fill = '0;
    logic [7:0] m_cnt  = '0;
    logic [1:0] m_cnt2 = '0;
    logic       m_z    = 1'b0;
    exp_t       sb_q[$];

    always #5 clk = ~clk;

    seq_detector_moore_param #(.PAT_LEN(4), .PATTERN(c_PAT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .w(w), .w_valid(w_valid),
        .overlap_en(overlap_en), .clear(clear),
        .z(z), .match_count(match_count), .fill(fill)
    );

    seq_detector_moore_param #(.PAT_LEN(4), .PATTERN(c_PAT), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .w(w), .w_valid(w_valid),
        .overlap_en(overlap_en), .clear(clear),
        .z(z_sat), .match_count(match_count_sat), .fill(fill_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Drive one cycle, advance the reference model, queue its expectation,
    // then compare the DUT outputs just after the capturing edge.
    task automatic step(input logic v, input logic b, input logic clr, input logic rst);
        logic [3:0] hn;
        logic [2:0] fn;
        exp_t       e;
        exp_t       got;
        @(negedge clk);
        reset = rst; clear = clr; w_valid = v; w = b;
        if (rst || clr) begin
            m_hist = '0; m_fill = '0; m_cnt = '0; m_cnt2 = '0; m_z = 1'b0;
        end else if (v) begin
            hn = {m_hist[2:0], b};
            fn = (m_fill >= 3'd4) ? 3'd4 : m_fill + 3'd1;
            m_hist = hn;
            if (fn == 3'd4 && hn == c_PAT) begin
                m_z = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
                m_fill = overlap_en ? 3'd4 : 3'd0;
            end else begin
                m_z = 1'b0;
                m_fill = fn;
            end
        end else begin
            m_z = 1'b0;
        end
        e.z = m_z; e.cnt = m_cnt; e.cnt_sat = m_cnt2; e.fill = m_fill;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("z", {31'd0, z}, {31'd0, got.z});
        chk("match_count", {24'd0, match_count}, {24'd0, got.cnt});
        chk("fill", {29'd0, fill}, {29'd0, got.fill});
        chk("z_sat", {31'd0, z_sat}, {31'd0, got.z});
        chk("match_count_sat", {30'd0, match_count_sat}, {30'd0, got.cnt_sat});
        chk("fill_sat", {29'd0, fill_sat}, {29'd0, got.fill});
    endtask

    task automatic send(input logic [6:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] pat_v;
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        pat_v   = c_PAT;

        // Reset held with valid data present
        overlap_en = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset_z", {31'd0, z}, 32'd0);
        chk("reset_fill", {29'd0, fill}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_reset_cnt", {24'd0, match_count}, 32'd0);

        // Overlapping detection of 1101101
        send(7'b1101101, 7);
        chk("ovl_cnt", {24'd0, match_count}, 32'd2);
        chk("ovl_fill", {29'd0, fill}, 32'd4);

        // Non-overlapping detection of the same stream
        step(1'b0, 1'b0, 1'b0, 1'b1);
        overlap_en = 1'b0;
        send(7'b1101101, 7);
        chk("novl_cnt", {24'd0, match_count}, 32'd1);
        chk("novl_fill", {29'd0, fill}, 32'd3);

        // Valid gaps between bits
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, pat_v[i], 1'b0, 1'b0);
            if (i == 0) chk("gap_z", {31'd0, z}, 32'd1);
            for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("gap_cnt", {24'd0, match_count}, 32'd1);

        // Clear mid-stream drops the concurrent bit
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send(7'b0000110, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("clear_fill", {29'd0, fill}, 32'd1);
        chk("clear_cnt", {24'd0, match_count}, 32'd0);

        // Saturation on the 2-bit counter instance
        step(1'b0, 1'b0, 1'b0, 1'b1);
        overlap_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(7'b0001101, 4);
            chk("sat_z", {31'd0, z_sat}, 32'd1);
            chk("sat_cnt", {30'd0, match_count_sat}, {30'd0, sat_exp[k]});
        end
        chk("wide_cnt", {24'd0, match_count}, 32'd5);

        // Overlap re-enabled mid-stream, then idle cycles
        overlap_en = 1'b1;
        send(7'b0101101, 6);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
